// File: rtl/ibex_rf_arb_pkg.sv
// Shared types and helpers for the register-file write-port arbiter.
// Arbiter priority state, register address width, register count.
package ibex_rf_arb_pkg;

  localparam int unsigned RegAddrW = 5;

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } arb_state_e;

  function automatic int unsigned NumRegs(input bit rv32e);
    return rv32e ? 32'd16 : 32'd32;
  endfunction

endpackage

// File: rtl/ibex_rf_wport_arbiter_if.sv
// Writeback requesters, pending-set, hazard lookup and RF write bundle.
// slave: arbiter side; master: requester/RF side.
interface ibex_rf_wport_arbiter_if #(
  parameter int unsigned DataWidth = 32
) ();
  import ibex_rf_arb_pkg::*;

  logic                 a_req_i;
  logic [RegAddrW-1:0]  a_addr_i;
  logic [DataWidth-1:0] a_wdata_i;
  logic                 a_gnt_o;
  logic                 b_req_i;
  logic [RegAddrW-1:0]  b_addr_i;
  logic [DataWidth-1:0] b_wdata_i;
  logic                 b_gnt_o;
  logic                 pend_set_i;
  logic [RegAddrW-1:0]  pend_addr_i;
  logic [RegAddrW-1:0]  raddr_a_i;
  logic [RegAddrW-1:0]  raddr_b_i;
  logic                 hazard_a_o;
  logic                 hazard_b_o;
  logic [RegAddrW-1:0]  rf_waddr_o;
  logic [DataWidth-1:0] rf_wdata_o;
  logic                 rf_we_o;
  logic                 err_o;

  modport slave (
    input  a_req_i, a_addr_i, a_wdata_i,
    input  b_req_i, b_addr_i, b_wdata_i,
    input  pend_set_i, pend_addr_i,
    input  raddr_a_i, raddr_b_i,
    output a_gnt_o, b_gnt_o,
    output hazard_a_o, hazard_b_o,
    output rf_waddr_o, rf_wdata_o, rf_we_o,
    output err_o
  );

  modport master (
    output a_req_i, a_addr_i, a_wdata_i,
    output b_req_i, b_addr_i, b_wdata_i,
    output pend_set_i, pend_addr_i,
    output raddr_a_i, raddr_b_i,
    input  a_gnt_o, b_gnt_o,
    input  hazard_a_o, hazard_b_o,
    input  rf_waddr_o, rf_wdata_o, rf_we_o,
    input  err_o
  );

endinterface

// File: rtl/ibex_rf_scoreboard.sv
// Pending bits for registers awaiting a long-latency write, hazard lookups.
// Ports: set/clear requests, two read addresses, hazards, error term (comb).
module ibex_rf_scoreboard
  import ibex_rf_arb_pkg::*;
#(
  parameter bit RV32E = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                set_i,
  input  logic [RegAddrW-1:0] set_addr_i,
  input  logic                clr_i,
  input  logic [RegAddrW-1:0] clr_addr_i,
  input  logic [RegAddrW-1:0] raddr_a_i,
  input  logic [RegAddrW-1:0] raddr_b_i,
  output logic                hazard_a_o,
  output logic                hazard_b_o,
  output logic                err_o
);

  localparam int unsigned NR = NumRegs(RV32E);

  logic [2**RegAddrW-1:0] pend_q, pend_d;
  logic set_en, clr_en, same;

  // x0 and out-of-range registers are never tracked
  assign set_en = set_i && (set_addr_i != '0)
               && (32'(set_addr_i) < NR);
  assign clr_en = clr_i && (clr_addr_i != '0);
  assign same   = clr_en && (clr_addr_i == set_addr_i);

  // set applied last so it wins over a same-cycle clear
  always_comb begin
    pend_d = pend_q;
    if (clr_en) pend_d[clr_addr_i] = 1'b0;
    if (set_en) pend_d[set_addr_i] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pend_q <= '0;
    else         pend_q <= pend_d;
  end

  assign hazard_a_o = pend_q[raddr_a_i];
  assign hazard_b_o = pend_q[raddr_b_i];

  assign err_o = (clr_en && !pend_q[clr_addr_i])
              || (set_en && pend_q[set_addr_i] && !same);

endmodule

// File: rtl/ibex_rf_wport_arbiter.sv
// Shares the RF write port between requester A and B, tracks pending B writes.
// Ports: clk_i, rst_ni, bus (slave). Macro IBEX_RF_ARB_STARVE_GUARD_EN enables B anti-starvation.
module ibex_rf_wport_arbiter
  import ibex_rf_arb_pkg::*;
#(
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned MaxWait   = 3
) (
  input logic                    clk_i,
  input logic                    rst_ni,
  ibex_rf_wport_arbiter_if.slave bus
);

  logic a_gnt, b_gnt, prio_b;
  logic sb_err, addr_err, err_q;
  logic [RegAddrW-1:0]  waddr;
  logic [DataWidth-1:0] wdata;

`ifdef IBEX_RF_ARB_STARVE_GUARD_EN
  localparam int unsigned CntW = $clog2(MaxWait + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxWait);

  arb_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= PRIO_A;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      PRIO_A: begin
        if (b_gnt) begin
          cnt_d = '0;
        end else if (bus.b_req_i) begin
          if (cnt_q != CntMax) cnt_d = cnt_q + CntW'(1);
          if (cnt_d == CntMax) state_d = PRIO_B;
        end
      end
      PRIO_B: begin
        if (b_gnt || !bus.b_req_i) begin
          state_d = PRIO_A;
          cnt_d   = '0;
        end
      end
    endcase
  end

  assign prio_b = (state_q == PRIO_B);
`else
  logic unused_max_wait;
  assign unused_max_wait = ^MaxWait;
  assign prio_b = 1'b0;
`endif

  assign a_gnt = bus.a_req_i && !(bus.b_req_i && prio_b);
  assign b_gnt = bus.b_req_i && !(bus.a_req_i && !prio_b);

  always_comb begin
    waddr = '0;
    wdata = '0;
    unique case (1'b1)
      a_gnt: begin
        waddr = bus.a_addr_i;
        wdata = bus.a_wdata_i;
      end
      b_gnt: begin
        waddr = bus.b_addr_i;
        wdata = bus.b_wdata_i;
      end
      default: ;
    endcase
  end

  ibex_rf_scoreboard #(
    .RV32E (RV32E)
  ) u_sb (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .set_i      (bus.pend_set_i),
    .set_addr_i (bus.pend_addr_i),
    .clr_i      (b_gnt),
    .clr_addr_i (bus.b_addr_i),
    .raddr_a_i  (bus.raddr_a_i),
    .raddr_b_i  (bus.raddr_b_i),
    .hazard_a_o (bus.hazard_a_o),
    .hazard_b_o (bus.hazard_b_o),
    .err_o      (sb_err)
  );

  // upper half of the register space does not exist in RV32E
  assign addr_err = RV32E && (
      (bus.a_req_i    && bus.a_addr_i[RegAddrW-1])
   || (bus.b_req_i    && bus.b_addr_i[RegAddrW-1])
   || (bus.pend_set_i && bus.pend_addr_i[RegAddrW-1]));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                  err_q <= 1'b0;
    else if (sb_err || addr_err)  err_q <= 1'b1;
  end

  assign bus.a_gnt_o    = a_gnt;
  assign bus.b_gnt_o    = b_gnt;
  assign bus.rf_we_o    = a_gnt | b_gnt;
  assign bus.rf_waddr_o = waddr;
  assign bus.rf_wdata_o = wdata;
  assign bus.err_o      = err_q;

endmodule
